// File: rtl/flit_transmitter.sv
// -----------------------------------------------------------------------------
// flit_transmitter
//
// Upstream end of a per-VC input-buffer link. Accepts a packet descriptor
// (length in flits) from a local source, allocates a free downstream virtual
// channel, then segments the payload stream into HEAD/BODY/TAIL (or HEADTAIL)
// flits on the router input link. Each downstream VC's on/off backpressure
// gates the payload handshake. A downstream VC becomes free again when the
// router pulses vc_allocatable_i after draining that VC's tail flit.
//
// Optional feature macro: FLIT_TRANSMITTER_RR_EN
//   defined   : round-robin VC allocation. The search starts one past the
//               last granted VC.
//   undefined : fixed priority. The lowest-index free VC wins, and no
//               pointer register exists.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   pkt_valid_i/len   packet descriptor (length 1..MAX_FLITS)
//   pkt_ready_o       descriptor accepted (high in IDLE)
//   data_valid_i/data payload for the next flit
//   data_ready_o      payload consumed (SEND and the current VC is on)
//   on_off_i          per-VC downstream backpressure, 1 = may send
//   vc_allocatable_i  per-VC one-cycle "VC is free again" pulse
//   valid_flit_o      data_o carries a new flit this cycle
//   data_o            flit {flit_label, vc_id, data}
//   error_o           registered one-cycle protocol error flag
// -----------------------------------------------------------------------------

package noc_params;
  localparam int VC_NUM         = 2;
  localparam int VC_SIZE        = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int FLIT_DATA_SIZE = 8;

  typedef enum logic [1:0] {
    HEAD     = 2'b00,
    BODY     = 2'b01,
    TAIL     = 2'b10,
    HEADTAIL = 2'b11
  } flit_label_t;

  typedef struct packed {
    flit_label_t               flit_label;
    logic [VC_SIZE-1:0]        vc_id;
    logic [FLIT_DATA_SIZE-1:0] data;
  } flit_t;
endpackage

module flit_transmitter
  import noc_params::*;
#(
  parameter  int MAX_FLITS = 8,
  localparam int LEN_W     = $clog2(MAX_FLITS + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pkt_valid_i,
  input  logic [LEN_W-1:0]          pkt_len_i,
  output logic                      pkt_ready_o,
  input  logic                      data_valid_i,
  input  logic [FLIT_DATA_SIZE-1:0] data_i,
  output logic                      data_ready_o,
  input  logic [VC_NUM-1:0]         on_off_i,
  input  logic [VC_NUM-1:0]         vc_allocatable_i,
  output logic                      valid_flit_o,
  output flit_t                     data_o,
  output logic                      error_o
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_FLITS);

  // The fourth 2-bit code is deliberately left unused. It is caught by the
  // default branch, which recovers to IDLE and flags an error.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALLOC = 2'd1,
    ST_SEND  = 2'd2
  } state_t;

  state_t             state_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [VC_SIZE-1:0] cur_vc_q;
  logic [VC_NUM-1:0]  vc_free_q;
  logic [VC_NUM-1:0]  vc_free_d;
  logic               valid_flit_q;
  flit_t              flit_q;
  logic               error_q;
  logic               error_d;

`ifdef FLIT_TRANSMITTER_RR_EN
  logic [VC_SIZE-1:0] rr_ptr_q;
  int unsigned        rr_idx;
`endif

  logic               len_ok;
  logic               illegal_state;
  logic               handshake;
  logic               grant_valid;
  logic [VC_SIZE-1:0] grant_vc;
  logic [VC_NUM-1:0]  grant_onehot;
  flit_label_t        label;
  logic               last_flit;

  // ---------------------------------------------------------------------------
  // Handshake outputs and protocol checks
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default value first. Without one,
  // a path that skips an assignment would infer a latch.
  always_comb begin
    pkt_ready_o   = 1'b0;
    data_ready_o  = 1'b0;
    illegal_state = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        pkt_ready_o   = 1'b1;
        illegal_state = 1'b0;
      end
      ST_ALLOC: illegal_state = 1'b0;
      ST_SEND: begin
        // This is the only combinational path from an input to an output.
        data_ready_o  = on_off_i[cur_vc_q];
        illegal_state = 1'b0;
      end
      default: illegal_state = 1'b1;
    endcase
  end

  always_comb begin
    len_ok    = (pkt_len_i != '0) && (pkt_len_i <= MAX_LEN);
    handshake = data_valid_i & data_ready_o;
  end

  // ---------------------------------------------------------------------------
  // VC selection. It uses only registered vc_free_q, so a vc_allocatable_i
  // pulse becomes visible to the selection one cycle later.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_valid  = 1'b0;
    grant_vc     = '0;
    grant_onehot = '0;
`ifdef FLIT_TRANSMITTER_RR_EN
    rr_idx       = 0;
    for (int i = 0; i < VC_NUM; i++) begin
      rr_idx = (int'(rr_ptr_q) + 1 + i) % VC_NUM;
      if (!grant_valid && vc_free_q[VC_SIZE'(rr_idx)]) begin
        grant_valid = 1'b1;
        grant_vc    = VC_SIZE'(rr_idx);
      end
    end
`else
    // Scan from the top down, so the lowest free index is written last and wins.
    for (int i = VC_NUM - 1; i >= 0; i--) begin
      if (vc_free_q[VC_SIZE'(i)]) begin
        grant_valid = 1'b1;
        grant_vc    = VC_SIZE'(i);
      end
    end
`endif
    grant_onehot[grant_vc] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Free-VC bookkeeping and error sources
  // ---------------------------------------------------------------------------
  always_comb begin
    vc_free_d = vc_free_q;
    if (state_q == ST_ALLOC && grant_valid) begin
      vc_free_d = vc_free_d & ~grant_onehot;
    end
    vc_free_d = vc_free_d | vc_allocatable_i;

    error_d = (|(vc_allocatable_i & vc_free_q))
            | (pkt_ready_o & pkt_valid_i & ~len_ok)
            | illegal_state;
  end

  // ---------------------------------------------------------------------------
  // Flit label, taken from the position of the flit within the packet
  // ---------------------------------------------------------------------------
  always_comb begin
    label = BODY;
    if (cnt_q == '0) begin
      label = (len_q == LEN_W'(1)) ? HEADTAIL : HEAD;
    end else if (cnt_q == len_q - LEN_W'(1)) begin
      label = TAIL;
    end
    last_flit = (label == TAIL) || (label == HEADTAIL);
  end

  // ---------------------------------------------------------------------------
  // FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples values from before the edge, and the order of the statements
  // does not matter. A later assignment to the same register overrides an
  // earlier default.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      cnt_q        <= '0;
      cur_vc_q     <= '0;
      vc_free_q    <= '1;
      valid_flit_q <= 1'b0;
      flit_q       <= '0;
      error_q      <= 1'b0;
`ifdef FLIT_TRANSMITTER_RR_EN
      rr_ptr_q     <= VC_SIZE'(VC_NUM - 1);
`endif
    end else begin
      vc_free_q    <= vc_free_d;
      error_q      <= error_d;
      valid_flit_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (pkt_valid_i && len_ok) begin
            len_q   <= pkt_len_i;
            cnt_q   <= '0;
            state_q <= ST_ALLOC;
          end
        end
        ST_ALLOC: begin
          if (grant_valid) begin
            cur_vc_q <= grant_vc;
`ifdef FLIT_TRANSMITTER_RR_EN
            rr_ptr_q <= grant_vc;
`endif
            state_q  <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (handshake) begin
            valid_flit_q <= 1'b1;
            flit_q       <= '{flit_label: label, vc_id: cur_vc_q, data: data_i};
            cnt_q        <= cnt_q + LEN_W'(1);
            if (last_flit) begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign valid_flit_o = valid_flit_q;
  assign data_o       = flit_q;
  assign error_o      = error_q;

endmodule

// File: tb/tb_flit_transmitter.sv
// -----------------------------------------------------------------------------
// tb_flit_transmitter
//
// Randomized scoreboard bench for flit_transmitter.
//
// The driver issues descriptors and payload. Its packet-level model keeps:
//   - the set of free downstream VCs,
//   - the last granted VC,
//   - each flit's position within its packet.
// For every accepted payload it pushes the expected flit and its arrival
// cycle into a queue. A separate monitor compares valid_flit_o/data_o and
// error_o against the queue and the expected error cycles.
// -----------------------------------------------------------------------------
module tb_flit_transmitter;
  import noc_params::*;

  localparam int MAX_FLITS = 8;
  localparam int LEN_W     = $clog2(MAX_FLITS + 1);

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      pkt_valid_i = 1'b0;
  logic [LEN_W-1:0]          pkt_len_i = '0;
  logic                      pkt_ready_o;
  logic                      data_valid_i = 1'b0;
  logic [FLIT_DATA_SIZE-1:0] data_i = '0;
  logic                      data_ready_o;
  logic [VC_NUM-1:0]         on_off_i = '1;
  logic [VC_NUM-1:0]         vc_allocatable_i = '0;
  logic                      valid_flit_o;
  flit_t                     data_o;
  logic                      error_o;

  flit_transmitter #(.MAX_FLITS(MAX_FLITS)) dut (
    .clk              (clk),
    .rst              (rst),
    .pkt_valid_i      (pkt_valid_i),
    .pkt_len_i        (pkt_len_i),
    .pkt_ready_o      (pkt_ready_o),
    .data_valid_i     (data_valid_i),
    .data_i           (data_i),
    .data_ready_o     (data_ready_o),
    .on_off_i         (on_off_i),
    .vc_allocatable_i (vc_allocatable_i),
    .valid_flit_o     (valid_flit_o),
    .data_o           (data_o),
    .error_o          (error_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    flit_t f;
    int    at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  bit   exp_err[int];
  bit   model_free[VC_NUM];
  int   rr_last;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic flit_label_t label_of(input int pos, input int len);
    if (len == 1)       return HEADTAIL;
    if (pos == 0)       return HEAD;
    if (pos == len - 1) return TAIL;
    return BODY;
  endfunction

  function automatic int pick_vc();
`ifdef FLIT_TRANSMITTER_RR_EN
    for (int i = 1; i <= VC_NUM; i++) begin
      int idx;
      idx = (rr_last + i) % VC_NUM;
      if (model_free[idx]) return idx;
    end
`else
    for (int i = 0; i < VC_NUM; i++) begin
      if (model_free[i]) return i;
    end
`endif
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < VC_NUM; i++) model_free[i] = 1'b1;
    rr_last = VC_NUM - 1;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (valid_flit_o) begin
        if (sb.size() == 0) begin
          check("unexpected_flit", 64'(1), 64'(0));
        end else begin
          mon_e = sb.pop_front();
          check("flit_cycle", 64'(cyc), 64'(mon_e.at));
          check("flit_label", 64'(data_o.flit_label), 64'(mon_e.f.flit_label));
          check("flit_vc", 64'(data_o.vc_id), 64'(mon_e.f.vc_id));
          check("flit_data", 64'(data_o.data), 64'(mon_e.f.data));
        end
      end else if (sb.size() > 0 && sb[0].at <= cyc) begin
        mon_e = sb.pop_front();
        check("flit_missing", 64'(0), 64'(1));
      end
      check("error_o", 64'(error_o), 64'(exp_err.exists(cyc)));
      if (exp_err.exists(cyc)) exp_err.delete(cyc);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks. Each starts and ends 1 time unit after a rising edge.
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic free_vc(input int v);
    vc_allocatable_i    = '0;
    vc_allocatable_i[v] = 1'b1;
    if (model_free[v]) exp_err[cyc + 1] = 1'b1;
    model_free[v] = 1'b1;
    tick();
    vc_allocatable_i = '0;
  endtask

  task automatic send_pkt(input int len, input bit rand_io, input int abort_after);
    bit     acc;
    int     t_acc;
    int     vc;
    int     start;
    int     pos;
    int     guard;
    int     v;
    bit     aborted;
    flit_t  ef;

    acc = 1'b0;
    aborted = 1'b0;
    pkt_valid_i = 1'b1;
    pkt_len_i   = LEN_W'(len);
    for (int w = 0; w < 20 && !acc; w++) begin
      @(negedge clk);
      if (pkt_ready_o) acc = 1'b1;
      else tick();
    end
    if (!acc) begin
      check("pkt_accept_timeout", 64'(0), 64'(1));
      pkt_valid_i = 1'b0;
      tick();
      return;
    end
    t_acc = cyc;

    if (len < 1 || len > MAX_FLITS) begin
      exp_err[t_acc + 1] = 1'b1;
      tick();
      pkt_valid_i = 1'b0;
      @(negedge clk);
      check("idle_after_bad_len", 64'(pkt_ready_o), 64'(1));
      tick();
      return;
    end

    tick();
    pkt_valid_i = 1'b0;

    vc    = pick_vc();
    start = t_acc + 2;
    if (vc < 0) begin
      // Every VC is busy. Show that nothing moves, then free one.
      data_valid_i = 1'b1;
      on_off_i     = '1;
      repeat (2 + $urandom % 4) begin
        @(negedge clk);
        check("ready_in_alloc", 64'(data_ready_o), 64'(0));
        tick();
      end
      v = $urandom % VC_NUM;
      vc_allocatable_i    = '0;
      vc_allocatable_i[v] = 1'b1;
      model_free[v] = 1'b1;
      start = cyc + 2;
      vc = pick_vc();
      @(negedge clk);
      check("ready_in_alloc", 64'(data_ready_o), 64'(0));
      tick();
      vc_allocatable_i = '0;
    end
    model_free[vc] = 1'b0;
    rr_last = vc;

    pos   = 0;
    guard = 0;
    while (pos < len && guard < 400) begin
      if (abort_after > 0 && pos == abort_after) begin
        aborted = 1'b1;
        break;
      end
      data_valid_i = rand_io ? (($urandom % 4) != 0) : 1'b1;
      data_i       = FLIT_DATA_SIZE'($urandom);
      for (int k = 0; k < VC_NUM; k++) on_off_i[k] = rand_io ? (($urandom % 4) != 0) : 1'b1;
      @(negedge clk);
      check("data_ready", 64'(data_ready_o), (cyc >= start) ? 64'(on_off_i[vc]) : 64'(0));
      check("pkt_ready_busy", 64'(pkt_ready_o), 64'(0));
      if (data_valid_i && data_ready_o) begin
        ef.flit_label = label_of(pos, len);
        ef.vc_id      = VC_SIZE'(vc);
        ef.data       = data_i;
        sb.push_back('{f: ef, at: cyc + 1});
        pos++;
      end
      tick();
      guard++;
    end
    data_valid_i = 1'b0;
    on_off_i     = '1;
    if (guard >= 400) begin
      check("send_timeout", 64'(0), 64'(1));
    end else if (!aborted) begin
      @(negedge clk);
      check("pkt_ready_after_tail", 64'(pkt_ready_o), 64'(1));
      tick();
    end
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    pkt_valid_i      = 1'b0;
    data_valid_i     = 1'b0;
    vc_allocatable_i = '0;
    tick();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_valid_flit", 64'(valid_flit_o), 64'(0));
    check("rst_data_o", 64'(data_o), 64'(0));
    check("rst_error", 64'(error_o), 64'(0));
    check("rst_pkt_ready", 64'(pkt_ready_o), 64'(1));
    check("rst_data_ready", 64'(data_ready_o), 64'(0));
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int len;
    model_reset();
    repeat (3) tick();
    mon_en = 1'b1;
    do_reset();

    // Single-flit packet, then a four-flit packet with random stalls.
    send_pkt(1, 1'b0, 0);
    free_vc(rr_last);
    send_pkt(4, 1'b1, 0);
    free_vc(rr_last);
    send_pkt(4, 1'b0, 0);
    free_vc(rr_last);

    // VC exhaustion. Send three packets without freeing any VC.
    send_pkt(1, 1'b0, 0);
    send_pkt(1, 1'b0, 0);
    send_pkt(1, 1'b0, 0);
    for (int v = 0; v < VC_NUM; v++) if (!model_free[v]) free_vc(v);

    // Allocation order. Free each VC right after its packet.
    repeat (4) begin
      send_pkt(2, 1'b0, 0);
      free_vc(rr_last);
    end

    // Protocol errors: zero length, oversize length, and freeing a free VC.
    send_pkt(0, 1'b0, 0);
    send_pkt(MAX_FLITS + 1, 1'b0, 0);
    free_vc(0);
    tick();

    // Reset in the middle of a packet, after its HEAD flit.
    send_pkt(4, 1'b0, 1);
    do_reset();
    send_pkt(1, 1'b0, 0);
    send_pkt(3, 1'b1, 0);
    free_vc(0);
    free_vc(1);

    // Randomized traffic.
    repeat (40) begin
      if ($urandom % 10 == 0) len = ($urandom % 2 == 0) ? 0 : MAX_FLITS + 1 + int'($urandom % 7);
      else                    len = 1 + int'($urandom % MAX_FLITS);
      send_pkt(len, 1'b1, 0);
      if ($urandom % 3 != 0) free_vc(int'($urandom % VC_NUM));
      repeat ($urandom % 3) tick();
    end

    repeat (5) tick();
    check("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
